ci_issuer: RTL and testbench

CI_ISSUER -- requirements
Module: ci_issuer

---
 rtl/ci_pkg.sv | 18 +
 rtl/ci_issuer.sv | 125 ++++++++++++
 tb/tb_ci_issuer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ci_pkg.sv
// Shared custom-instruction bus definitions: FSM state encoding, bus widths and
// the operand-A command codes understood by counter-style responders.
package ci_pkg;

    localparam int unsigned CI_ID_WIDTH   = 8;
    localparam int unsigned CI_DATA_WIDTH = 32;

    localparam logic [CI_DATA_WIDTH-1:0] CI_A_READ  = 32'd0;
    localparam logic [CI_DATA_WIDTH-1:0] CI_A_RESET = 32'd1;

    typedef logic [1:0] ciState_t;

    localparam ciState_t IDLE    = 2'd0;
    localparam ciState_t ISSUE   = 2'd1;
    localparam ciState_t WAIT    = 2'd2;
    localparam ciState_t RESPOND = 2'd3;

endpackage

// File: rtl/ci_issuer.sv
// Single-outstanding command issuer for the shared custom-instruction bus.
// Optional WAIT timeout is enabled with the CI_ISSUER_TIMEOUT_EN macro.
module ci_issuer
    import ci_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd255
) (
    input  logic                     systemClock,
    input  logic                     reset,

    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [CI_ID_WIDTH-1:0]   cmdN,
    input  logic [CI_DATA_WIDTH-1:0] cmdValueA,
    input  logic [CI_DATA_WIDTH-1:0] cmdValueB,

    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [CI_DATA_WIDTH-1:0] rspResult,
    output logic                     rspTimeout,

    output logic                     ciStart,
    output logic                     ciCke,
    output logic [CI_ID_WIDTH-1:0]   ciN,
    output logic [CI_DATA_WIDTH-1:0] ciValueA,
    output logic [CI_DATA_WIDTH-1:0] ciValueB,
    input  logic [CI_DATA_WIDTH-1:0] ciResult,
    input  logic                     ciDone
);

    ciState_t                 stateQ, stateD;
    logic [CI_ID_WIDTH-1:0]   idQ;
    logic [CI_DATA_WIDTH-1:0] valueAQ, valueBQ;
    logic [CI_DATA_WIDTH-1:0] resultQ;
    logic                     accept;
    logic                     inFlight;
    logic                     busActive;
    logic                     expired;

    assign accept   = (stateQ == IDLE) && cmdValid;
    assign inFlight = (stateQ == ISSUE) || (stateQ == WAIT);

`ifdef CI_ISSUER_TIMEOUT_EN
    logic [31:0] waitCountQ;
    logic [31:0] waitNext;
    logic        timeoutQ;

    assign waitNext = waitCountQ + 32'd1;
    // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a coincident ciDone still wins below.
    assign expired  = (stateQ == WAIT) && (waitNext >= TIMEOUT_CYCLES);

    always_ff @(posedge systemClock) begin
        if (reset) begin
            waitCountQ <= '0;
            timeoutQ   <= 1'b0;
        end else begin
            if (accept) begin
                waitCountQ <= '0;
            end else if (stateQ == WAIT) begin
                waitCountQ <= waitNext;
            end
            if (inFlight && ciDone) begin
                timeoutQ <= 1'b0;
            end else if (expired) begin
                timeoutQ <= 1'b1;
            end
        end
    end

    assign rspTimeout = timeoutQ;
`else
    logic unusedTimeoutCycles;

    assign unusedTimeoutCycles = ^TIMEOUT_CYCLES;
    assign expired             = 1'b0;
    assign rspTimeout          = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (cmdValid) stateD = ISSUE;
            ISSUE:   stateD = ciDone ? RESPOND : WAIT;
            WAIT:    if (ciDone || expired) stateD = RESPOND;
            RESPOND: if (rspReady) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge systemClock) begin
        if (reset) begin
            stateQ  <= IDLE;
            idQ     <= '0;
            valueAQ <= '0;
            valueBQ <= '0;
            resultQ <= '0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                idQ     <= cmdN;
                valueAQ <= cmdValueA;
                valueBQ <= cmdValueB;
            end
            if (inFlight && ciDone) begin
                resultQ <= ciResult;
            end else if (expired) begin
                resultQ <= '0;
            end
        end
    end

    // Gate on reset as well so the shared bus is quiet even before the first reset edge.
    assign busActive = inFlight && !reset;

    assign cmdReady  = (stateQ == IDLE);
    assign rspValid  = (stateQ == RESPOND) && !reset;
    assign rspResult = resultQ;

    assign ciStart  = (stateQ == ISSUE) && !reset;
    assign ciCke    = busActive;
    assign ciN      = busActive ? idQ : '0;
    assign ciValueA = busActive ? valueAQ : '0;
    assign ciValueB = busActive ? valueBQ : '0;

endmodule

// File: tb/tb_ci_issuer.sv
// Directed bench for ci_issuer with three modelled CI responders on an OR-combined bus.
module tb_ci_issuer;
    import ci_pkg::*;

    logic        systemClock;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [7:0]  cmdN;
    logic [31:0] cmdValueA;
    logic [31:0] cmdValueB;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspResult;
    logic        rspTimeout;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;

    int nTests = 0;
    int nFail  = 0;
    int ckeCount;
    logic stable;

    ci_issuer #(
        .TIMEOUT_CYCLES(32'd8)
    ) dut (
        .systemClock(systemClock),
        .reset      (reset),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdN       (cmdN),
        .cmdValueA  (cmdValueA),
        .cmdValueB  (cmdValueB),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspResult  (rspResult),
        .rspTimeout (rspTimeout),
        .ciStart    (ciStart),
        .ciCke      (ciCke),
        .ciN        (ciN),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciResult   (ciResult),
        .ciDone     (ciDone)
    );

    initial systemClock = 1'b0;
    always #5 systemClock = ~systemClock;

    // Responders: ID 5 combinational, ID 7 done 3 cycles after start, ID 1 bus error counter.
    logic        done5, done7, done1, lateDone;
    logic [31:0] res5, res7, res1, lateResult;
    logic [1:0]  delayCount = 2'd0;
    logic [31:0] errCount   = 32'd5;

    always_comb begin
        done5 = ciStart && (ciN == 8'd5);
        res5  = done5 ? 32'h0000_CAFE : 32'd0;
        done7 = ciCke && (ciN == 8'd7) && (delayCount == 2'd3);
        res7  = done7 ? 32'h0000_0012 : 32'd0;
        done1 = ciStart && (ciN == 8'd1);
        res1  = (done1 && (ciValueA == CI_A_READ)) ? errCount : 32'd0;
    end

    assign ciDone   = done5 | done7 | done1 | lateDone;
    assign ciResult = res5 | res7 | res1 | (lateDone ? lateResult : 32'd0);

    always @(posedge systemClock) begin
        if (ciStart && (ciN == 8'd7)) begin
            delayCount <= 2'd1;
        end else if (delayCount != 2'd0 && delayCount != 2'd3) begin
            delayCount <= delayCount + 2'd1;
        end else begin
            delayCount <= 2'd0;
        end
        if (done1 && (ciValueA == CI_A_RESET)) begin
            errCount <= 32'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge systemClock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        cmdValid   = 1'b0;
        cmdN       = 8'd0;
        cmdValueA  = 32'd0;
        cmdValueB  = 32'd0;
        rspReady   = 1'b0;
        lateDone   = 1'b0;
        lateResult = 32'd0;
        tick();
        tick();
        check("rst_cmdReady", {31'd0, cmdReady}, 32'd1);
        check("rst_rspValid", {31'd0, rspValid}, 32'd0);
        check("rst_ciCke", {31'd0, ciCke}, 32'd0);
        check("rst_ciStart", {31'd0, ciStart}, 32'd0);
        check("rst_rspResult", rspResult, 32'd0);
        reset = 1'b0;
        tick();

        // Combinational responder, done in the start cycle.
        cmdValid  = 1'b1;
        cmdN      = 8'd5;
        cmdValueA = CI_A_READ;
        cmdValueB = 32'd0;
        check("c5_cmdReady_T", {31'd0, cmdReady}, 32'd1);
        tick();
        cmdValid = 1'b0;
        check("c5_ciStart_T1", {31'd0, ciStart}, 32'd1);
        check("c5_ciN_T1", {24'd0, ciN}, 32'd5);
        check("c5_rspValid_T1", {31'd0, rspValid}, 32'd0);
        check("c5_cmdReady_T1", {31'd0, cmdReady}, 32'd0);
        tick();
        check("c5_rspValid_T2", {31'd0, rspValid}, 32'd1);
        check("c5_rspResult", rspResult, 32'h0000_CAFE);
        check("c5_rspTimeout", {31'd0, rspTimeout}, 32'd0);
        check("c5_ciCke_T2", {31'd0, ciCke}, 32'd0);
        check("c5_ciStart_T2", {31'd0, ciStart}, 32'd0);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        check("c5_back_idle", {31'd0, cmdReady}, 32'd1);

        // Error counter: read, clear, then back-to-back read.
        cmdValid  = 1'b1;
        cmdN      = 8'd1;
        cmdValueA = CI_A_READ;
        tick();
        cmdValid = 1'b0;
        tick();
        check("err_pre_read", rspResult, 32'd5);
        rspReady  = 1'b1;
        cmdValid  = 1'b1;
        cmdValueA = CI_A_RESET;
        tick();
        rspReady = 1'b0;
        check("err_idle_before_clear", {31'd0, cmdReady}, 32'd1);
        tick();
        check("err_clear_valueA", ciValueA, 32'd1);
        tick();
        check("err_clear_rsp", rspResult, 32'd0);
        cmdValueA = CI_A_READ;
        rspReady  = 1'b1;
        tick();
        rspReady = 1'b0;
        tick();
        cmdValid = 1'b0;
        check("err_read_valueA", ciValueA, 32'd0);
        tick();
        check("err_read_after_clear", rspResult, 32'd0);
        check("err_read_rspValid", {31'd0, rspValid}, 32'd1);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;

        // Delayed responder: done 3 cycles after start.
        cmdValid  = 1'b1;
        cmdN      = 8'd7;
        cmdValueA = 32'h1111_2222;
        cmdValueB = 32'h3333_4444;
        tick();
        cmdValid = 1'b0;
        ckeCount = 0;
        stable   = 1'b1;
        for (int g = 0; g < 20 && !rspValid; g++) begin
            if (ciCke) begin
                ckeCount++;
                if (ciN != 8'd7 || ciValueA != 32'h1111_2222 || ciValueB != 32'h3333_4444) begin
                    stable = 1'b0;
                end
            end
            tick();
        end
        check("d7_rsp_seen", {31'd0, rspValid}, 32'd1);
        check("d7_cke_cycles", ckeCount, 32'd4);
        check("d7_operands_stable", {31'd0, stable}, 32'd1);
        check("d7_rspResult", rspResult, 32'h0000_0012);
        check("d7_rspTimeout", {31'd0, rspTimeout}, 32'd0);

        // Response back-pressure with a second command pending.
        cmdValid = 1'b1;
        cmdN     = 8'd5;
        stable   = 1'b1;
        for (int h = 0; h < 10; h++) begin
            tick();
            if (!rspValid || rspResult != 32'h0000_0012 || cmdReady || ciStart) begin
                stable = 1'b0;
            end
        end
        check("hold_rsp_stable", {31'd0, stable}, 32'd1);
        cmdValid = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        check("hold_release_idle", {31'd0, cmdReady}, 32'd1);
        tick();
        check("hold_second_not_issued", {31'd0, ciStart}, 32'd0);

        // No responder: ID 9.
        cmdValid  = 1'b1;
        cmdN      = 8'd9;
        cmdValueA = 32'h0000_00AA;
        cmdValueB = 32'h0000_00BB;
        tick();
        cmdValid = 1'b0;
`ifdef CI_ISSUER_TIMEOUT_EN
        ckeCount = 0;
        for (int k = 0; k < 40 && !rspValid; k++) begin
            if (ciCke) ckeCount++;
            tick();
        end
        check("to_rsp_seen", {31'd0, rspValid}, 32'd1);
        check("to_cke_window", {31'd0, (ckeCount >= 8 && ckeCount <= 10)}, 32'd1);
        check("to_rspTimeout", {31'd0, rspTimeout}, 32'd1);
        check("to_rspResult", rspResult, 32'd0);
        check("to_ciCke_low", {31'd0, ciCke}, 32'd0);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("nto_no_rsp", {31'd0, rspValid}, 32'd0);
        check("nto_still_cke", {31'd0, ciCke}, 32'd1);
        check("nto_rspTimeout", {31'd0, rspTimeout}, 32'd0);
`endif

        // Reset mid-WAIT, then a late ciDone.
        check("rw_in_wait", {31'd0, ciCke}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw_cke_during_reset", {31'd0, ciCke}, 32'd0);
        check("rw_ciN_during_reset", {24'd0, ciN}, 32'd0);
        tick();
        reset      = 1'b0;
        lateDone   = 1'b1;
        lateResult = 32'h0000_DEAD;
        tick();
        lateDone = 1'b0;
        check("rw_no_rspValid", {31'd0, rspValid}, 32'd0);
        check("rw_cmdReady", {31'd0, cmdReady}, 32'd1);
        check("rw_ciCke", {31'd0, ciCke}, 32'd0);
        check("rw_ciStart", {31'd0, ciStart}, 32'd0);
        check("rw_ciN", {24'd0, ciN}, 32'd0);
        check("rw_ciValueA", ciValueA, 32'd0);
        check("rw_ciValueB", ciValueB, 32'd0);
        check("rw_rspResult", rspResult, 32'd0);
        check("rw_rspTimeout", {31'd0, rspTimeout}, 32'd0);
        tick();
        check("rw_still_no_rsp", {31'd0, rspValid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
